// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & ~(PC_STEP - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries; DEPTH must be a power of two (2, 4 or 8).
// flush empties the buffer on the next edge and wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t entry,
    output logic         full,
    output logic         almost_full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count == CNT_W'(DEPTH - 1));

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, redirect handling and a prefetch FIFO.
// Optional starvation counter enabled by macro FETCH_CTRL_PERF_EN.
//
// state | meaning
// BOOT  | first cycle after reset release; no fetch
// RUN   | fetching one word per cycle into the prefetch FIFO
// FULL  | FIFO full and not draining; fetch PC held
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [31:0]           out_pc,
    output logic [31:0]           stall_cnt
);

    fetch_state_e state;
    fetch_state_e state_next;
    logic [31:0]  fetch_pc;
    logic         push;
    logic         pop;
    logic         flush;
    logic         fifo_full;
    logic         fifo_almost_full;
    logic         fifo_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = RUN;
        end else begin
            case (state)
                BOOT:    state_next = RUN;
                // Without a pop the FIFO is full after this edge whenever it is full or one short now.
                RUN:     if (!pop && (fifo_full || fifo_almost_full)) state_next = FULL;
                FULL:    if (pop) state_next = RUN;
                default: state_next = BOOT;
            endcase
        end
    end

    always_comb begin
        pop   = out_valid && out_ready && !redirect_valid;
        flush = redirect_valid;
        push  = 1'b0;
        if (state == RUN && !redirect_valid) push = !fifo_full || pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              fetch_pc <= RESET_PC;
        else if (redirect_valid) fetch_pc <= word_align(redirect_pc);
        else if (push)           fetch_pc <= fetch_pc + PC_STEP;
    end

    assign imem_addr        = fetch_pc[ADDR_WIDTH+1:2];
    assign push_entry.pc    = fetch_pc;
    assign push_entry.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .pop         (pop),
        .flush       (flush),
        .entry       (push_entry),
        .full        (fifo_full),
        .almost_full (fifo_almost_full),
        .empty       (fifo_empty),
        .head        (head)
    );

    // Storage is not reset, so an empty buffer presents zeros rather than stale data.
    assign out_valid = !fifo_empty;
    assign out_instr = fifo_empty ? 32'd0 : head.instr;
    assign out_pc    = fifo_empty ? 32'd0 : head.pc;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_ready && !out_valid && state != BOOT && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the driver keeps a queue of expected PCs for the
// current fetch stream, the monitor compares and retires entries on every valid output.
module tb_fetch_ctrl;

    localparam int          AW    = 10;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef FETCH_CTRL_PERF_EN
    localparam logic [31:0] PERF  = 32'd1;
`else
    localparam logic [31:0] PERF  = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = 32'd0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [31:0]   stall_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] stream_next = RPC;
    logic        redir_pending = 1'b0;
    logic [31:0] redir_target = 32'd0;
    logic [31:0] s0;

    always #5 clk = ~clk;

    // ROM contents: word i holds the value i.
    assign imem_rdata = 32'(imem_addr);

    fetch_ctrl #(
        .ADDR_WIDTH     (AW),
        .FIFO_DEPTH     (DEPTH),
        .RESET_PC       (RPC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .stall_cnt      (stall_cnt)
    );

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return (pc >> 2) % (32'd1 << AW);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; returns shortly after the falling edge so outputs are settled.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rp);
        @(negedge clk);
        if (redir_pending) begin
            exp_q.delete();
            stream_next   = redir_target;
            redir_pending = 1'b0;
        end
        while (exp_q.size() < 16) begin
            exp_q.push_back(stream_next);
            stream_next = stream_next + 32'd4;
        end
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        if (rv) begin
            redir_pending = 1'b1;
            redir_target  = rp & ~32'd3;
        end
        #2;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_pc", out_pc, 32'd0);
        check("rst_async_stall", stall_cnt, 32'd0);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset(input logic boot_rv, input logic [31:0] boot_pc);
        @(negedge clk);
        exp_q.delete();
        redir_pending  = 1'b0;
        stream_next    = boot_rv ? (boot_pc & ~32'd3) : RPC;
        out_ready      = 1'b1;
        redirect_valid = boot_rv;
        redirect_pc    = boot_pc;
        rst_n          = 1'b1;
    endtask

    // Monitor: compares every presented entry with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #1;
`ifndef FETCH_CTRL_PERF_EN
            check("stall_cnt_zero", stall_cnt, 32'd0);
`endif
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_empty: got pc %h, expected no output", out_pc);
                end else begin
                    check("stream_pc", out_pc, exp_q[0]);
                    check("stream_instr", out_instr, word_of(exp_q[0]));
                    if (out_ready && !redirect_valid) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #3;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_pc", out_pc, 32'd0);
        check("reset_instr", out_instr, 32'd0);
        check("reset_stall", stall_cnt, 32'd0);
        check("reset_imem_addr", 32'(imem_addr), word_of(RPC));

        // First fetch after reset release
        release_reset(1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("boot_valid_low", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, RPC);
        check("first_instr", out_instr, word_of(RPC));
        check("first_stall", stall_cnt, PERF);
        repeat (6) step(1'b1, 1'b0, 32'd0);

        // Backpressure: FIFO fills, fetch address freezes
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 32'd0);
            if (k >= 8) begin
                check("full_imem_addr", 32'(imem_addr), word_of(exp_q[0] + 32'(4 * DEPTH)));
                check("full_valid", 32'(out_valid), 32'd1);
            end
        end
        for (int k = 0; k < DEPTH + 3; k++) begin
            step(1'b1, 1'b0, 32'd0);
            check("resume_no_gap", 32'(out_valid), 32'd1);
        end

        // Redirect while full
        repeat (10) step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b0, 32'd0);
        check("redir_bubble_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("redir_valid", 32'(out_valid), 32'd1);
        check("redir_pc", out_pc, 32'h40);
        check("redir_instr", out_instr, 32'd16);

        // Starvation counter across one redirect bubble
        repeat (3) step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h200);
        s0 = stall_cnt;
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("bubble_stall_delta", stall_cnt, s0 + PERF);
        step(1'b1, 1'b0, 32'd0);
        check("bubble_stall_hold", stall_cnt, s0 + PERF);

        // Unaligned redirect at the top of the ROM, then address wrap
        step(1'b1, 1'b1, 32'h0000_0FFE);
        step(1'b1, 1'b0, 32'd0);
        check("wrap_addr_top", 32'(imem_addr), 32'h3FF);
        step(1'b1, 1'b0, 32'd0);
        check("wrap_pc_top", out_pc, 32'hFFC);
        check("wrap_addr_zero", 32'(imem_addr), 32'd0);
        repeat (3) step(1'b1, 1'b0, 32'd0);

        // Mid-stream reset restarts at RESET_PC
        assert_reset();
        release_reset(1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("rerst_valid_low", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("rerst_pc", out_pc, RPC);

        // Redirect during BOOT skips RESET_PC
        assert_reset();
        release_reset(1'b1, 32'h83);
        step(1'b1, 1'b0, 32'd0);
        check("boot_redir_valid_low", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("boot_redir_pc", out_pc, 32'h80);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                assert_reset();
                release_reset(1'($urandom_range(0, 1)), $urandom);
            end else begin
                step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 5), $urandom);
            end
        end
        repeat (20) step(1'b1, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
